// File: rtl/rca_result_accumulator.sv
// Frame accumulator behind the ripple-carry adder: sums COUNT {carry, sum} results
// into one total and presents it downstream on a registered valid/ready port.
module rca_result_accumulator #(
    parameter int SIZE  = 4,
    parameter int COUNT = 4,
    parameter int ACC_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SIZE-1:0]  in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);
    localparam int CNT_W = $clog2(COUNT);
    localparam int SUM_W = ACC_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic [ACC_W-1:0] total_q, total_d;
    logic             ovf_q, ovf_d;

    logic [SIZE:0]    operand;
    logic [SUM_W-1:0] addFull;
    logic             accept;
    logic             outHs;
    logic             lastBeat;

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign out_total = total_q;
    assign out_ovf   = ovf_q;

    // The extra top bit of addFull is the carry-out of the ACC_W-wide add.
    assign operand  = {in_carry, in_sum};
    assign addFull  = {1'b0, acc_q} + SUM_W'(operand);
    assign accept   = in_valid & in_ready;
    assign outHs    = out_valid & out_ready;
    assign lastBeat = (cnt_q == LAST);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        total_d  = total_q;
        ovf_d    = ovf_q;
        // Clear wins over both handshakes but leaves the last published total alone.
        if (clear) begin
            state_d  = ACCUM;
            acc_d    = '0;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (accept) begin
            if (lastBeat) begin
                total_d  = addFull[ACC_W-1:0];
                ovf_d    = sticky_q | addFull[ACC_W];
                acc_d    = '0;
                cnt_d    = '0;
                sticky_d = 1'b0;
                state_d  = DONE;
            end else begin
                acc_d    = addFull[ACC_W-1:0];
                sticky_d = sticky_q | addFull[ACC_W];
                cnt_d    = cnt_q + CNT_W'(1);
            end
        end else if (outHs) begin
            state_d = ACCUM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            total_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            total_q  <= total_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule

// File: tb/tb_rca_result_accumulator.sv
// Drives a 7-bit and a 5-bit accumulator with identical traffic and compares both
// against a frame-level integer-sum model.
module tb_rca_result_accumulator;
    localparam int SIZE  = 4;
    localparam int COUNT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_sum = '0;
    logic       in_carry = 1'b0;
    logic       out_ready = 1'b0;

    logic       inReady7, outValid7, outOvf7;
    logic [6:0] outTotal7;
    logic       inReady5, outValid5, outOvf5;
    logic [4:0] outTotal5;

    int vectors = 0;
    int miscompares = 0;

    // Model: a frame is just a running integer sum and a count of accepted operands.
    int         frameSum = 0;
    int         frameCnt = 0;
    logic       mDone = 1'b0;
    logic [6:0] mTot7 = '0;
    logic       mOvf7 = 1'b0;
    logic [4:0] mTot5 = '0;
    logic       mOvf5 = 1'b0;

    rca_result_accumulator #(.SIZE(SIZE), .COUNT(COUNT), .ACC_W(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(inReady7),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(outValid7), .out_ready(out_ready),
        .out_total(outTotal7), .out_ovf(outOvf7)
    );

    rca_result_accumulator #(.SIZE(SIZE), .COUNT(COUNT), .ACC_W(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(inReady5),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(outValid5), .out_ready(out_ready),
        .out_total(outTotal5), .out_ovf(outOvf5)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] exp7();
        return {mDone, ~mDone, mOvf7, mTot7};
    endfunction

    function automatic logic [7:0] exp5();
        return {mDone, ~mDone, mOvf5, mTot5};
    endfunction

    task automatic modelReset();
        frameSum = 0;
        frameCnt = 0;
        mDone    = 1'b0;
        mTot7    = '0;
        mOvf7    = 1'b0;
        mTot5    = '0;
        mOvf5    = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model, and returns 1ns after the edge.
    task automatic applyStimulus(input logic v, input logic c, input logic [3:0] s,
                                 input logic r, input logic clr);
        in_valid  = v;
        in_carry  = c;
        in_sum    = s;
        out_ready = r;
        clear     = clr;
        if (clr) begin
            frameSum = 0;
            frameCnt = 0;
            mDone    = 1'b0;
        end else if (!mDone && v) begin
            frameSum += int'(c) * 16 + int'(s);
            frameCnt++;
            if (frameCnt == COUNT) begin
                mTot7    = 7'(frameSum % 128);
                mOvf7    = (frameSum >= 128);
                mTot5    = 5'(frameSum % 32);
                mOvf5    = (frameSum >= 32);
                frameSum = 0;
                frameCnt = 0;
                mDone    = 1'b1;
            end
        end else if (mDone && r) begin
            mDone = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        modelReset();
        applyStimulus(1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd4, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        vectors++;
        if ({outValid7, inReady7, outOvf7, outTotal7} !== 10'b01_0_0000000) begin
            miscompares++;
            $display("[TB] FAIL reset7: got %b expected %b", {outValid7, inReady7, outOvf7, outTotal7}, 10'b0100000000);
        end
        vectors++;
        if ({outValid5, inReady5, outOvf5, outTotal5} !== 8'b01_0_00000) begin
            miscompares++;
            $display("[TB] FAIL reset5: got %b expected %b", {outValid5, inReady5, outOvf5, outTotal5}, 8'b01000000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [4] = '{5'd3, 5'd5, 5'd18, 5'd31};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, ops[i][4], ops[i][3:0], 1'b1, 1'b0);
            vectors++;
            if (outValid7 !== (i == 3)) begin
                miscompares++;
                $display("[TB] FAIL b2b_valid beat %0d: got %b expected %b", i, outValid7, (i == 3));
            end
        end
        vectors++;
        if ({outValid7, inReady7, outOvf7, outTotal7} !== {2'b10, 1'b0, 7'd57}) begin
            miscompares++;
            $display("[TB] FAIL b2b_total7: got %b expected %b", {outValid7, inReady7, outOvf7, outTotal7}, {2'b10, 1'b0, 7'd57});
        end
        vectors++;
        if ({outValid5, inReady5, outOvf5, outTotal5} !== exp5()) begin
            miscompares++;
            $display("[TB] FAIL b2b_total5: got %b expected %b", {outValid5, inReady5, outOvf5, outTotal5}, exp5());
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd7, 1'b0, 1'b0);
            vectors++;
            if ({outValid7, inReady7, outTotal7} !== {2'b10, 7'd57}) begin
                miscompares++;
                $display("[TB] FAIL hold cycle %0d: got %b expected %b", i, {outValid7, inReady7, outTotal7}, {2'b10, 7'd57});
            end
        end
        applyStimulus(1'b0, 1'b0, 4'd7, 1'b1, 1'b0);
        vectors++;
        if ({outValid7, inReady7, outTotal7} !== {2'b01, 7'd57}) begin
            miscompares++;
            $display("[TB] FAIL release: got %b expected %b", {outValid7, inReady7, outTotal7}, {2'b01, 7'd57});
        end
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
        vectors++;
        if ({outValid7, outOvf7, outTotal7} !== {2'b10, 7'd4}) begin
            miscompares++;
            $display("[TB] FAIL ones_frame: got %b expected %b", {outValid7, outOvf7, outTotal7}, {2'b10, 7'd4});
        end
    endtask

    task automatic test_bubbles();
        logic [6:0] pattern = 7'b1101001;
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (pattern[i])
                applyStimulus(1'b1, 1'b0, 4'd10, 1'b0, 1'b0);
            else
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
            vectors++;
            if (outValid7 !== (i == 6)) begin
                miscompares++;
                $display("[TB] FAIL bubble_valid step %0d: got %b expected %b", i, outValid7, (i == 6));
            end
        end
        vectors++;
        if ({outValid7, outOvf7, outTotal7} !== {2'b10, 7'd40}) begin
            miscompares++;
            $display("[TB] FAIL bubble_total: got %b expected %b", {outValid7, outOvf7, outTotal7}, {2'b10, 7'd40});
        end
    endtask

    task automatic test_clear();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd9, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd9, 1'b0, 1'b1);
        repeat (4) applyStimulus(1'b1, 1'b0, 4'd2, 1'b0, 1'b0);
        vectors++;
        if ({outValid7, outTotal7} !== {1'b1, 7'd8}) begin
            miscompares++;
            $display("[TB] FAIL clear_frame: got %b expected %b", {outValid7, outTotal7}, {1'b1, 7'd8});
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        vectors++;
        if ({outValid7, inReady7, outTotal7} !== {2'b01, 7'd8}) begin
            miscompares++;
            $display("[TB] FAIL clear_done: got %b expected %b", {outValid7, inReady7, outTotal7}, {2'b01, 7'd8});
        end
    endtask

    task automatic test_overflow();
        repeat (4) applyStimulus(1'b1, 1'b1, 4'd15, 1'b0, 1'b0);
        vectors++;
        if ({outValid5, outOvf5, outTotal5} !== {2'b11, 5'd28}) begin
            miscompares++;
            $display("[TB] FAIL ovf5: got %b expected %b", {outValid5, outOvf5, outTotal5}, {2'b11, 5'd28});
        end
        vectors++;
        if ({outValid7, outOvf7, outTotal7} !== {2'b10, 7'd124}) begin
            miscompares++;
            $display("[TB] FAIL ovf7: got %b expected %b", {outValid7, outOvf7, outTotal7}, {2'b10, 7'd124});
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 4'(i), 1'b0, 1'b0);
        vectors++;
        if ({outValid5, outOvf5, outTotal5} !== {2'b10, 5'd10}) begin
            miscompares++;
            $display("[TB] FAIL ovf5_next: got %b expected %b", {outValid5, outOvf5, outTotal5}, {2'b10, 5'd10});
        end
    endtask

    task automatic test_random();
        applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            vectors++;
            if ({outValid7, inReady7, outOvf7, outTotal7} !== exp7()) begin
                miscompares++;
                $display("[TB] FAIL rand7 cycle %0d: got %b expected %b", i, {outValid7, inReady7, outOvf7, outTotal7}, exp7());
            end
            vectors++;
            if ({outValid5, inReady5, outOvf5, outTotal5} !== exp5()) begin
                miscompares++;
                $display("[TB] FAIL rand5 cycle %0d: got %b expected %b", i, {outValid5, inReady5, outOvf5, outTotal5}, exp5());
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_bubbles();
        test_clear();
        test_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
